u_rx: RTL

U_RX -- requirements
Module: u_rx

---
 rtl/u_rx.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/u_rx.sv
// u_rx: oversampled 8-bit UART receiver (8 data bits LSB first, one stop bit).
// Define U_RX_PARITY_EN to add one even-parity bit after D7 and drive rx_parity_err.
module u_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_en_rx,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_frame_err,
  output logic       rx_parity_err
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    HOLD
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shift;
  logic            rx_meta;
  logic            rx_s;
  logic            run;
  logic            armed;
  logic            tick;
`ifdef U_RX_PARITY_EN
  logic            par_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // run stays low on the first edge after release so a tick on that edge is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  assign tick = baud_en_rx & run;

  // armed requires the line to be seen high after reset, so a line that is
  // already low at release (mid-frame) is not taken as a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= 3'd0;
      shift        <= 8'h00;
      data_out     <= 8'h00;
      rx_valid     <= 1'b0;
      rx_active    <= 1'b0;
      rx_frame_err <= 1'b0;
      armed        <= 1'b0;
`ifdef U_RX_PARITY_EN
      rx_parity_err <= 1'b0;
      par_bad       <= 1'b0;
`endif
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef U_RX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      if (tick) begin
        case (state)
          IDLE: begin
            if (rx_s) begin
              armed <= 1'b1;
            end else if (armed) begin
              state     <= START;
              cnt       <= '0;
              rx_active <= 1'b1;
            end
          end
          START: begin
            if (cnt == HALF) begin
              cnt <= '0;
              if (!rx_s) begin
                state <= DATA;
                idx   <= 3'd0;
              end else begin
                state     <= IDLE;
                rx_active <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == LAST) begin
              cnt        <= '0;
              shift[idx] <= rx_s;
              if (idx == 3'd7) begin
`ifdef U_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                idx <= idx + 3'd1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef U_RX_PARITY_EN
          PARITY: begin
            if (cnt == LAST) begin
              cnt     <= '0;
              par_bad <= rx_s ^ (^shift);
              state   <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (cnt == LAST) begin
              cnt <= '0;
`ifdef U_RX_PARITY_EN
              rx_parity_err <= par_bad;
              par_bad       <= 1'b0;
`endif
              if (rx_s) begin
                data_out  <= shift;
                rx_valid  <= 1'b1;
                state     <= IDLE;
                rx_active <= 1'b0;
              end else begin
                rx_frame_err <= 1'b1;
                state        <= HOLD;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HOLD: begin
            if (rx_s) begin
              state     <= IDLE;
              rx_active <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            cnt       <= '0;
            rx_active <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef U_RX_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

  a_valid_ferr_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(rx_valid && rx_frame_err));
  a_valid_one_clk: assert property (@(posedge clk) disable iff (!rst_n)
    rx_valid |=> !rx_valid);
  a_ferr_one_clk: assert property (@(posedge clk) disable iff (!rst_n)
    rx_frame_err |=> !rx_frame_err);

endmodule
